locked_reg_bank: RTL and testbench
==================================

Name: locked_reg_bank

Overview:
Parametrised bank of NUM_REGS write-protected registers, each WIDTH bits wide, with a per-register sticky lock bit. Once a register is locked, writes to it are dropped and flagged. Locks clear only on reset or on a correct two-word key unlock sequence. Repeated bad keys escalate to a tamper state that freezes all locks until reset. The block sits in the access-control layer between the config bus and protected configuration state.

Parameters:
WIDTH, 8, data width of each register
NUM_REGS, 4, number of registers (1..16; need not be a power of two)
ADDR_W, 2, address width; must satisfy 2**ADDR_W >= NUM_REGS
RESET_VAL, 0, reset value of every register (WIDTH bits)
KEY0, 8'hA5, first unlock key word (WIDTH bits)
KEY1, 8'h5A, second unlock key word (WIDTH bits)
MAX_FAILS, 3, bad-key attempts before tamper (1..15)

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
write_en  input  1  write strobe for addr/data_in
addr  input  ADDR_W  target register for write_en and lock_set
data_in  input  WIDTH  write data
lock_set  input  1  set lock bit of register addr
key_valid  input  1  key_data is valid this cycle
key_data  input  WIDTH  unlock key word
data_out  output  NUM_REGS*WIDTH  all registers, reg i at bits [i*WIDTH +: WIDTH]
lock_status  output  NUM_REGS  current lock bits
write_err  output  1  one-cycle pulse, previous-cycle write was rejected
tamper  output  1  sticky, fail limit reached

Behaviour:
- Reset (resetn=0, asynchronous): all registers = RESET_VAL; lock_status = 0; write_err = 0; tamper = 0; FSM = IDLE; fail_cnt = 0.
- Write: write_en=1 with addr < NUM_REGS and lock_status[addr]=0 -> register loads data_in at the edge; new value is visible on data_out the next cycle. Otherwise the register holds its value.
- Rejected write: write_en=1 with the addr register locked, or addr >= NUM_REGS -> no state change; write_err=1 for exactly the following cycle.
- Lock: lock_set=1 sets lock_status[addr] at the edge. Ignored if addr >= NUM_REGS. No error is raised on re-locking.
- Write and lock_set in the same cycle to an unlocked addr: the write succeeds and the lock sets; later writes are rejected.
- The lock check always uses the lock state before the edge.
- Unlock FSM (states IDLE, GOT_K0, TAMPER); it advances only on key_valid=1:
  - IDLE: key_data==KEY0 -> GOT_K0. Any other word -> fail, stay IDLE.
  - GOT_K0: key_data==KEY1 -> clear all lock bits, fail_cnt=0, -> IDLE. Any other word -> fail, -> IDLE.
  - In GOT_K0 with key_valid=0, the FSM holds; there is no timeout.
  - Fail: fail_cnt += 1. If it reaches MAX_FAILS -> TAMPER, tamper=1.
  - TAMPER: absorbing until reset. Key input is ignored; lock_set still works; locks can no longer be cleared.
- Unlock completion and lock_set in the same cycle: all locks clear except lock_status[addr], which ends set (lock_set wins).
- Write to a locked register in the unlock-completion cycle: rejected with write_err (uses the pre-edge lock).
- fail_cnt saturates and is internal only. It is not reset by successful writes, only by a correct unlock or by reset.
- Reset asserted mid-sequence (GOT_K0) returns the FSM to IDLE; partial key progress is lost.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, write addr=2 data=8'h3C -> cycle+1 reg2=8'h3C, write_err=0; other regs remain 8'h00.
- lock_set addr=1 and write addr=1 data=8'h11 in the same cycle; then write addr=1 data=8'h22 -> reg1=8'h11, lock_status=4'b0010, write_err pulses once after the second write.
- Lock regs 0 and 3; send key A5 then 5A with 2 idle cycles between -> lock_status=0 after the 5A cycle; a following write to reg0 succeeds.
- Keys A5,00 / 11 / A5,A5 (three fails, MAX_FAILS=3) -> tamper=1 after the third fail; subsequent A5,5A leave locks unchanged.
- NUM_REGS=3, write addr=3 -> write_err pulse, no register changes; lock_set addr=3 -> lock_status unchanged.
- Send A5, assert resetn=0 mid-sequence, release, send 5A -> counted as a fail (fail_cnt=1), locks unchanged; all outputs at reset values during reset.

Source files
------------

// File: rtl/locked_reg_bank.sv
// locked_reg_bank: a bank of write-protected registers, each with a sticky lock bit.
// A two-word key sequence clears every lock at once. Repeated bad keys drive
// the block into a tamper state, which freezes the locks until reset.
module locked_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter int               NUM_REGS  = 4,
  parameter int               ADDR_W    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] KEY0      = 8'hA5,
  parameter logic [WIDTH-1:0] KEY1      = 8'h5A,
  parameter int               MAX_FAILS = 3
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      write_en,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      lock_set,
  input  logic                      key_valid,
  input  logic [WIDTH-1:0]          key_data,
  output logic [NUM_REGS*WIDTH-1:0] data_out,
  output logic [NUM_REGS-1:0]       lock_status,
  output logic                      write_err,
  output logic                      tamper
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GOT_K0 = 2'd1,
    TAMPER = 2'd2
  } state_t;

  // One extra bit so that NUM_REGS == 2**ADDR_W still fits in the compare constant.
  localparam logic [ADDR_W:0] NREGS_W = NUM_REGS[ADDR_W:0];
  localparam logic [3:0]      MAX_F   = MAX_FAILS[3:0];

  state_t                    state_q, state_d;
  logic [3:0]                fail_q, fail_d;
  logic [NUM_REGS*WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]       lock_q, lock_d;
  logic                      werr_q, werr_d;
  logic                      tamper_q, tamper_d;

  logic                      addr_ok;
  logic                      lock_at_addr;
  logic                      wr_ok;
  logic                      unlock;
  logic                      bad_key;
  logic [3:0]                fail_inc;

  // Address decode and write acceptance. Acceptance uses the lock bits as they
  // were before the clock edge.
  always_comb begin
    addr_ok      = ({1'b0, addr} < NREGS_W);
    lock_at_addr = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) lock_at_addr = lock_q[i];
    end
    wr_ok  = write_en && addr_ok && !lock_at_addr;
    werr_d = write_en && !wr_ok;
  end

  // Unlock FSM: next state, the fail counter and the unlock strobe.
  always_comb begin
    state_d  = state_q;
    fail_d   = fail_q;
    unlock   = 1'b0;
    bad_key  = 1'b0;
    fail_inc = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
    if (key_valid) begin
      case (state_q)
        IDLE: begin
          if (key_data == KEY0) state_d = GOT_K0;
          else                  bad_key = 1'b1;
        end
        GOT_K0: begin
          state_d = IDLE;
          if (key_data == KEY1) begin
            unlock = 1'b1;
            fail_d = 4'd0;
          end else begin
            bad_key = 1'b1;
          end
        end
        TAMPER:  state_d = TAMPER;
        default: state_d = IDLE;
      endcase
    end
    if (bad_key) begin
      fail_d = fail_inc;
      if (fail_inc >= MAX_F) state_d = TAMPER;
    end
    tamper_d = (state_d == TAMPER);
  end

  // Register file and lock bits. A lock_set issued in the same cycle as an
  // unlock wins for its own address.
  always_comb begin
    regs_d = regs_q;
    lock_d = lock_q;
    if (unlock) lock_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) begin
        if (wr_ok)               regs_d[i*WIDTH +: WIDTH] = data_in;
        if (lock_set && addr_ok) lock_d[i] = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Data, lock, fail-count and status flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      regs_q   <= {NUM_REGS{RESET_VAL}};
      lock_q   <= '0;
      fail_q   <= 4'd0;
      werr_q   <= 1'b0;
      tamper_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      lock_q   <= lock_d;
      fail_q   <= fail_d;
      werr_q   <= werr_d;
      tamper_q <= tamper_d;
    end
  end

  assign data_out    = regs_q;
  assign lock_status = lock_q;
  assign write_err   = werr_q;
  assign tamper      = tamper_q;

endmodule

// File: tb/tb_locked_reg_bank.sv
// Directed testbench for locked_reg_bank. It drives two instances from the same
// inputs: a 4-register bank and a 3-register bank. The 3-register bank exercises
// the out-of-range address.
module tb_locked_reg_bank;

  logic        clk = 1'b0;
  logic        resetn;
  logic        write_en;
  logic [1:0]  addr;
  logic [7:0]  data_in;
  logic        lock_set;
  logic        key_valid;
  logic [7:0]  key_data;

  logic [31:0] data_out;
  logic [3:0]  lock_status;
  logic        write_err;
  logic        tamper;

  logic [23:0] d3_data;
  logic [2:0]  d3_lock;
  logic        d3_werr;
  logic        d3_tamper;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  locked_reg_bank dut (
    .clk(clk), .resetn(resetn), .write_en(write_en), .addr(addr),
    .data_in(data_in), .lock_set(lock_set), .key_valid(key_valid),
    .key_data(key_data), .data_out(data_out), .lock_status(lock_status),
    .write_err(write_err), .tamper(tamper)
  );

  locked_reg_bank #(.NUM_REGS(3), .ADDR_W(2)) dut3 (
    .clk(clk), .resetn(resetn), .write_en(write_en), .addr(addr),
    .data_in(data_in), .lock_set(lock_set), .key_valid(key_valid),
    .key_data(key_data), .data_out(d3_data), .lock_status(d3_lock),
    .write_err(d3_werr), .tamper(d3_tamper)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    write_en  = 1'b0;
    addr      = 2'd0;
    data_in   = 8'h00;
    lock_set  = 1'b0;
    key_valid = 1'b0;
    key_data  = 8'h00;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    write_en = 1'b1; addr = a; data_in = d;
    cyc();
    clr_in();
  endtask

  task automatic do_lock(input logic [1:0] a);
    lock_set = 1'b1; addr = a;
    cyc();
    clr_in();
  endtask

  task automatic do_key(input logic [7:0] k);
    key_valid = 1'b1; key_data = k;
    cyc();
    clr_in();
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_data"},   data_out,    32'h0);
    check_val({tag, "_lock"},   {28'h0, lock_status}, 32'h0);
    check_val({tag, "_werr"},   {31'h0, write_err},   32'h0);
    check_val({tag, "_tamper"}, {31'h0, tamper},      32'h0);
  endtask

  initial begin
    clr_in();
    resetn = 1'b0;
    #12;
    check_reset_outs("rst0");
    check_val("rst0_d3data", {8'h0, d3_data}, 32'h0);
    cyc();
    resetn = 1'b1;

    // Plain write to reg2.
    do_write(2'd2, 8'h3C);
    check_val("wr2_data", data_out, 32'h003C_0000);
    check_val("wr2_werr", {31'h0, write_err}, 32'h0);

    // Write and lock reg1 in the same cycle, then a rejected write.
    write_en = 1'b1; lock_set = 1'b1; addr = 2'd1; data_in = 8'h11;
    cyc();
    clr_in();
    check_val("wl1_data", data_out, 32'h003C_1100);
    check_val("wl1_lock", {28'h0, lock_status}, 32'h2);
    do_write(2'd1, 8'h22);
    check_val("rej1_werr", {31'h0, write_err}, 32'h1);
    check_val("rej1_data", data_out, 32'h003C_1100);
    cyc();
    check_val("rej1_werr_clr", {31'h0, write_err}, 32'h0);

    // Lock regs 0 and 3, then unlock with idle cycles between the key words.
    do_lock(2'd0);
    do_lock(2'd3);
    check_val("lk03_lock", {28'h0, lock_status}, 32'hB);
    do_key(8'hA5);
    cyc();
    cyc();
    check_val("k0_hold_lock", {28'h0, lock_status}, 32'hB);
    do_key(8'h5A);
    check_val("unlock_lock", {28'h0, lock_status}, 32'h0);
    do_write(2'd0, 8'h77);
    check_val("postunl_data", data_out, 32'h003C_1177);
    check_val("postunl_werr", {31'h0, write_err}, 32'h0);

    // Unlock completing in the same cycle as a lock_set and a write to a locked reg.
    do_lock(2'd1);
    do_key(8'hA5);
    key_valid = 1'b1; key_data = 8'h5A;
    lock_set = 1'b1; write_en = 1'b1; addr = 2'd1; data_in = 8'h99;
    cyc();
    clr_in();
    check_val("race_lock", {28'h0, lock_status}, 32'h2);
    check_val("race_werr", {31'h0, write_err}, 32'h1);
    check_val("race_data", data_out, 32'h003C_1177);

    // Three bad keys lead to tamper.
    do_key(8'hA5); do_key(8'h00);
    do_key(8'h11);
    check_val("fail2_tamper", {31'h0, tamper}, 32'h0);
    do_key(8'hA5); do_key(8'hA5);
    check_val("fail3_tamper", {31'h0, tamper}, 32'h1);
    do_lock(2'd0);
    check_val("tmp_lockset", {28'h0, lock_status}, 32'h3);
    do_key(8'hA5); do_key(8'h5A);
    check_val("tmp_nounlock", {28'h0, lock_status}, 32'h3);
    check_val("tmp_sticky", {31'h0, tamper}, 32'h1);

    // Reset, then the out-of-range address on the 3-register bank.
    resetn = 1'b0;
    #2;
    check_reset_outs("rst1");
    cyc();
    resetn = 1'b1;
    do_write(2'd3, 8'h55);
    check_val("oor_werr", {31'h0, d3_werr}, 32'h1);
    check_val("oor_data", {8'h0, d3_data}, 32'h0);
    check_val("inr_data4", data_out, 32'h5500_0000);
    do_lock(2'd3);
    check_val("oor_lock", {29'h0, d3_lock}, 32'h0);
    check_val("oor_werr_clr", {31'h0, d3_werr}, 32'h0);

    // Reset in the middle of a key sequence drops the partial progress.
    resetn = 1'b0;
    #2;
    cyc();
    resetn = 1'b1;
    do_lock(2'd0);
    do_key(8'hA5);
    resetn = 1'b0;
    #2;
    check_reset_outs("rst2");
    cyc();
    resetn = 1'b1;
    do_lock(2'd0);
    do_key(8'h5A);
    check_val("midrst_lock", {28'h0, lock_status}, 32'h1);
    check_val("midrst_tamper", {31'h0, tamper}, 32'h0);
    do_key(8'h5A);
    check_val("midrst_f2_tamper", {31'h0, tamper}, 32'h0);
    do_key(8'h5A);
    check_val("midrst_f3_tamper", {31'h0, tamper}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
